gate_exerciser: RTL and testbench

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_exerciser_if.sv | 31 +++
 rtl/gate_exerciser.sv | 179 +++++++++++++++++
 tb/tb_gate_exerciser.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if -- bundle of the exerciser's control, stimulus and result
// signals.
//   master : used by gate_exerciser.
//            inputs : start, op, out2
//            outputs: in1, in2, busy, done, pass, err_count, fail_valid,
//                     fail_vec
//   slave  : used by the environment, i.e. the host plus the gate under test.
//            Directions are the reverse of master.
interface gate_exerciser_if;
  logic       start;
  logic [2:0] op;
  logic       in1;
  logic       in2;
  logic       out2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [1:0] fail_vec;

  modport master (
    input  start, op, out2,
    output in1, in2, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    output start, op, out2,
    input  in1, in2, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// gate_exerciser -- sweeps a 2-input gate through {in2,in1} = 00,01,10,11.
// Each vector is held for STEP_CYCLES clocks, and the sweep is repeated
// NUM_PASSES times. At the last dwell cycle of each vector, the synchronized
// gate response is compared with the expected function selected by op. The
// block keeps a saturating mismatch count and the first failing vector.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gate_exerciser_if.master
//           start/op         : run request and gate function (latched at start)
//           in1/in2          : registered stimulus, 0 outside RUN
//           out2             : gate response, asynchronous to clk
//           busy/done/pass   : run status (done is a one-cycle pulse in FIN)
//           err_count        : saturating mismatch count
//           fail_valid/vec   : first mismatching vector
module gate_exerciser #(
  parameter int STEP_CYCLES = 8,
  parameter int NUM_PASSES  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gate_exerciser_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [6:0] PASS_LAST  = 7'(NUM_PASSES - 1);

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] vec;
  logic [1:0] vec_inc;
  logic [7:0] dwell;
  logic [6:0] pass_cnt;
  logic       out2_p0;
  logic       out2_p1;
  logic       in1_q;
  logic       in2_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] err_q;
  logic       fail_valid_q;
  logic [1:0] fail_vec_q;

  logic       at_cmp;
  logic       mismatch;
  logic       last_cmp;
  logic [7:0] err_next;

  // Expected gate output for vector v; codes 6 and 7 fall back to AND.
  function automatic logic expected(input logic [2:0] f, input logic [1:0] v);
    logic a;
    logic b;
    a = v[0];
    b = v[1];
    case (f)
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      default: return a & b;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the asynchronous gate response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_p0 <= 1'b0;
      out2_p1 <= 1'b0;
    end else begin
      out2_p0 <= bus.out2;
      out2_p1 <= out2_p0;
    end
  end

  always_comb begin
    at_cmp   = (state == RUN) && (dwell == DWELL_LAST);
    mismatch = at_cmp && (out2_p1 != expected(op_q, vec));
    err_next = mismatch ? sat_inc(err_q) : err_q;
    last_cmp = at_cmp && (vec == 2'd3) && (pass_cnt == PASS_LAST);
    vec_inc  = vec + 2'd1;
  end

  // Stage p2: sequencer, compare and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= 3'd0;
      vec          <= 2'd0;
      dwell        <= 8'd0;
      pass_cnt     <= 7'd0;
      in1_q        <= 1'b0;
      in2_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 8'd0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q         <= bus.op;
            err_q        <= 8'd0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            pass_q       <= 1'b0;
            vec          <= 2'd0;
            dwell        <= 8'd0;
            pass_cnt     <= 7'd0;
            in1_q        <= 1'b0;
            in2_q        <= 1'b0;
            busy_q       <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          err_q <= err_next;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec;
          end
          if (at_cmp) begin
            dwell <= 8'd0;
            vec   <= vec_inc;
            if (vec == 2'd3) begin
              pass_cnt <= pass_cnt + 7'd1;
            end
            if (last_cmp) begin
              // err_next already includes the final compare of the run.
              state  <= FIN;
              done_q <= 1'b1;
              pass_q <= (err_next == 8'd0);
              in1_q  <= 1'b0;
              in2_q  <= 1'b0;
            end else begin
              in1_q <= vec_inc[0];
              in2_q <= vec_inc[1];
            end
          end else begin
            dwell <= dwell + 8'd1;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in1        = in1_q;
  assign bus.in2        = in2_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser -- randomized and directed bench for gate_exerciser.
// Three instances cover the configurations below:
//   a : default timing (8 cycles per vector, 4 passes)
//   b : 3 cycles per vector, 64 passes (count/saturation runs)
//   c : 3 cycles per vector, 4 passes (response latency runs)
// The gate under test is a behavioural model. It is a gate function, a stuck
// value or an inverted gate, with 0..3 extra clocked delay stages on out2.
module tb_gate_exerciser;

  logic clk;
  logic rst_n;

  gate_exerciser_if ia ();
  gate_exerciser_if ib ();
  gate_exerciser_if ic ();

  gate_exerciser #(.STEP_CYCLES(8), .NUM_PASSES(4))  u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  gate_exerciser #(.STEP_CYCLES(3), .NUM_PASSES(64)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  gate_exerciser #(.STEP_CYCLES(3), .NUM_PASSES(4))  u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Host drive and gate-model configuration
  int         sel = 0;
  logic       start_d = 1'b0;
  logic [2:0] op_d = 3'd0;
  int         dmode = 0;
  bit         dinv = 1'b0;
  logic [1:0] dlat = 2'd0;

  assign ia.start = (sel == 0) ? start_d : 1'b0;
  assign ib.start = (sel == 1) ? start_d : 1'b0;
  assign ic.start = (sel == 2) ? start_d : 1'b0;
  assign ia.op = op_d;
  assign ib.op = op_d;
  assign ic.op = op_d;

  // Ideal gate behaviour for the six defined functions; 6/7 act as AND
  function automatic bit gate_fn(input int f, input bit a, input bit b);
    case (f)
      1:       return !(a && b);
      2:       return a || b;
      3:       return !(a || b);
      4:       return a != b;
      5:       return a == b;
      default: return a && b;
    endcase
  endfunction

  // Gate-under-test model: mode 0..5 gate function, 6 stuck-0, 7 stuck-1
  function automatic bit dut_fn(input int mode, input bit inv, input bit a, input bit b);
    bit r;
    if (mode == 6)      r = 1'b0;
    else if (mode == 7) r = 1'b1;
    else                r = gate_fn(mode, a, b);
    return r ^ inv;
  endfunction

  function automatic logic pick(input logic [1:0] lat, input logic c, input logic [2:0] h);
    case (lat)
      2'd0:    return c;
      2'd1:    return h[0];
      2'd2:    return h[1];
      default: return h[2];
    endcase
  endfunction

  logic       ca, cb, cc;
  logic [2:0] ha = 3'd0;
  logic [2:0] hb = 3'd0;
  logic [2:0] hc = 3'd0;
  assign ca = dut_fn(dmode, dinv, ia.in1, ia.in2);
  assign cb = dut_fn(dmode, dinv, ib.in1, ib.in2);
  assign cc = dut_fn(dmode, dinv, ic.in1, ic.in2);
  always @(posedge clk) begin
    ha <= {ha[1:0], ca};
    hb <= {hb[1:0], cb};
    hc <= {hc[1:0], cc};
  end
  assign ia.out2 = pick(dlat, ca, ha);
  assign ib.out2 = pick(dlat, cb, hb);
  assign ic.out2 = pick(dlat, cc, hc);

  // Observation mux for the selected instance
  logic       s_busy, s_done, s_pass, s_in1, s_in2, s_fv;
  logic [7:0] s_err;
  logic [1:0] s_fvec;
  always_comb begin
    s_busy = ia.busy; s_done = ia.done; s_pass = ia.pass; s_in1 = ia.in1;
    s_in2 = ia.in2; s_fv = ia.fail_valid; s_err = ia.err_count; s_fvec = ia.fail_vec;
    if (sel == 1) begin
      s_busy = ib.busy; s_done = ib.done; s_pass = ib.pass; s_in1 = ib.in1;
      s_in2 = ib.in2; s_fv = ib.fail_valid; s_err = ib.err_count; s_fvec = ib.fail_vec;
    end else if (sel == 2) begin
      s_busy = ic.busy; s_done = ic.done; s_pass = ic.pass; s_in1 = ic.in1;
      s_in2 = ic.in2; s_fv = ic.fail_valid; s_err = ic.err_count; s_fvec = ic.fail_vec;
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model of one run.
  // Global vector k is compared in cycle k*sc+sc-1 of RUN. The two-stage
  // synchronizer means that compare sees out2 as it was two cycles earlier.
  // A model latency of lat cycles pushes this back further, to the stimulus
  // present at cycle k*sc+sc-3-lat. Before RUN the stimulus is 00.
  task automatic ref_run(input int sc, input int np, input int op, input int mode,
                         input bit inv, input int lat,
                         output int errs, output int fvec, output int fvalid);
    errs = 0; fvec = 0; fvalid = 0;
    for (int k = 0; k < 4 * np; k++) begin
      int v, c, vin;
      bit obs, want;
      v    = k % 4;
      c    = k * sc + sc - 3 - lat;
      vin  = (c < 0) ? 0 : (c / sc) % 4;
      obs  = dut_fn(mode, inv, vin[0], vin[1]);
      want = gate_fn(op, v[0], v[1]);
      if (obs != want) begin
        if (errs < 255) errs++;
        if (fvalid == 0) begin
          fvalid = 1;
          fvec   = v;
        end
      end
    end
  endtask

  task automatic do_run(input int s, input int op, input int mode, input bit inv,
                        input int lat, input bit hold, input bit fin_start, input string tag);
    int sc, np, errs, fvec, fvalid, busy_n, done_n, seq_bad, cyc, want_vec;
    sc = (s == 0) ? 8 : 3;
    np = (s == 1) ? 64 : 4;
    sel = s; dmode = mode; dinv = inv; dlat = 2'(lat);
    repeat (5) @(negedge clk);
    ref_run(sc, np, op, mode, inv, lat, errs, fvec, fvalid);
    op_d = 3'(op);
    start_d = 1'b1;
    @(negedge clk);
    if (!hold) start_d = 1'b0;
    chk({tag, ".pass_clr"}, int'(s_pass), 0);
    busy_n = 0; done_n = 0; seq_bad = 0; cyc = 0;
    while (s_busy && cyc < 20000) begin
      want_vec = (cyc < 4 * np * sc) ? (cyc / sc) % 4 : 0;
      if (int'({s_in2, s_in1}) != want_vec) seq_bad++;
      busy_n++;
      if (s_done) begin
        done_n++;
        if (hold || fin_start) start_d = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    start_d = 1'b0;
    chk({tag, ".busy_cycles"}, busy_n, 4 * np * sc + 1);
    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".stim_seq_errs"}, seq_bad, 0);
    chk({tag, ".err_count"}, int'(s_err), errs);
    chk({tag, ".pass"}, int'(s_pass), (errs == 0) ? 1 : 0);
    chk({tag, ".fail_valid"}, int'(s_fv), fvalid);
    chk({tag, ".fail_vec"}, int'(s_fvec), fvec);
    repeat (4) @(negedge clk);
    chk({tag, ".idle_busy"}, int'(s_busy), 0);
    chk({tag, ".hold_err"}, int'(s_err), errs);
    chk({tag, ".hold_pass"}, int'(s_pass), (errs == 0) ? 1 : 0);
  endtask

  initial begin
    rst_n = 1'b0;
    #23;
    chk("rst.busy", int'(ia.busy), 0);
    chk("rst.done", int'(ia.done), 0);
    chk("rst.pass", int'(ia.pass), 0);
    chk("rst.err", int'(ia.err_count), 0);
    chk("rst.fail_valid", int'(ia.fail_valid), 0);
    chk("rst.stim", int'({ia.in2, ia.in1}), 0);
    chk("rst.b_busy", int'(ib.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal AND, op AND; then AND model checked as OR (8 errors, first 01)
    do_run(0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "and_ideal");
    do_run(0, 2, 0, 1'b0, 0, 1'b0, 1'b0, "and_as_or");

    // Stuck faults and saturation over 64 passes
    do_run(1, 1, 7, 1'b0, 0, 1'b0, 1'b0, "stuck1_nand");
    do_run(1, 1, 6, 1'b0, 0, 1'b0, 1'b0, "stuck0_nand");
    do_run(1, 0, 0, 1'b1, 0, 1'b0, 1'b0, "inv_and_sat");

    // Response latency at 3 cycles per vector
    do_run(2, 0, 0, 1'b0, 0, 1'b0, 1'b0, "lat2_total");
    do_run(2, 0, 0, 1'b0, 1, 1'b0, 1'b0, "lat3_total");

    // Start held high for a whole run, and start pulsed in FIN
    do_run(0, 4, 4, 1'b0, 0, 1'b1, 1'b0, "start_held");
    do_run(0, 5, 3, 1'b0, 0, 1'b0, 1'b1, "start_in_fin");

    // Reset in the middle of a failing run
    sel = 0; dmode = 0; dinv = 1'b0; dlat = 2'd0;
    repeat (5) @(negedge clk);
    op_d = 3'd2;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    repeat (49) @(negedge clk);
    chk("midrst.pre_fail_valid", int'(ia.fail_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(ia.busy), 0);
    chk("midrst.done", int'(ia.done), 0);
    chk("midrst.err", int'(ia.err_count), 0);
    chk("midrst.fail_valid", int'(ia.fail_valid), 0);
    chk("midrst.fail_vec", int'(ia.fail_vec), 0);
    chk("midrst.stim", int'({ia.in2, ia.in1}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.no_done", int'(ia.done), 0);
    do_run(0, 0, 0, 1'b0, 0, 1'b0, 1'b0, "post_rst");

    // Randomized runs across all configurations
    for (int i = 0; i < 10; i++) begin
      int s;
      s = (i % 3 == 1) ? 2 : 0;
      if (i == 9) s = 1;
      do_run(s, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
